// File: rtl/dunit_idex_dumper.sv
// Debug-unit reader for the ID/EX latch: snapshots the latch outputs while halted
// and streams them as a 20-byte frame (header + 19 data bytes) over a valid/ready byte port.
module dunit_idex_dumper #(
    parameter int          NB_REG  = 32,
    parameter int          NB_CTRL = 18,
    parameter int          NB_BYTE = 8,
    parameter logic [7:0]  HEADER  = 8'hA5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_REG-1:0]  i_pc_eight,
    input  logic [NB_REG-1:0]  i_rs_data,
    input  logic [NB_REG-1:0]  i_rt_data,
    input  logic [NB_REG-1:0]  i_sign_extension,
    input  logic [NB_CTRL-1:0] i_control_unit,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int         NB_CTRL_PAD = 24;
    localparam int         NB_SNAP     = NB_BYTE + 4 * NB_REG + NB_CTRL_PAD;
    localparam logic [4:0] LAST_BYTE   = 5'd19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [NB_SNAP-1:0] snap, snap_next;
    logic [4:0]         cnt, cnt_next;
    logic               valid_next, busy_next, done_next;
    logic               xfer;

    // The snapshot holds the whole frame with the header on top; the byte on the
    // wire is always the top byte, and each accepted byte shifts the next one up.
    assign o_tx_data = snap[NB_SNAP-1 -: NB_BYTE];
    assign xfer      = o_tx_valid && i_tx_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            snap       <= '0;
            cnt        <= '0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state      <= state_next;
            snap       <= snap_next;
            cnt        <= cnt_next;
            o_tx_valid <= valid_next;
            o_busy     <= busy_next;
            o_done     <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        snap_next  = snap;
        cnt_next   = cnt;
        valid_next = o_tx_valid;
        busy_next  = o_busy;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    snap_next  = {HEADER[NB_BYTE-1:0], i_pc_eight, i_rs_data, i_rt_data,
                                  i_sign_extension, NB_CTRL_PAD'(i_control_unit)};
                    cnt_next   = '0;
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    snap_next = snap << NB_BYTE;
                    if (cnt == LAST_BYTE) begin
                        cnt_next   = '0;
                        valid_next = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt + 5'd1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dunit_idex_dumper.sv
// Directed bench for dunit_idex_dumper: expected frame bytes are queued at start
// and popped on every observed transfer.
module tb_dunit_idex_dumper;

    logic        i_clk = 1'b0;
    logic        i_reset, i_start, i_tx_ready;
    logic [31:0] pc, rs, rt, se;
    logic [17:0] ctrl;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid, o_busy, o_done;

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    logic [7:0]  exp_q[$];
    logic        hold_pending = 1'b0;
    logic [7:0]  held = 8'h00;

    dunit_idex_dumper dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_start          (i_start),
        .i_pc_eight       (pc),
        .i_rs_data        (rs),
        .i_rt_data        (rt),
        .i_sign_extension (se),
        .i_control_unit   (ctrl),
        .o_tx_data        (o_tx_data),
        .o_tx_valid       (o_tx_valid),
        .i_tx_ready       (i_tx_ready),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called once per cycle at the falling edge, i.e. mid-cycle.
    task automatic monitor();
        logic [7:0] e;
        if (hold_pending) begin
            check("hold_valid", 32'(o_tx_valid), 32'd1);
            check("hold_data", 32'(o_tx_data), 32'(held));
        end
        hold_pending = 1'b0;
        if (o_done) done_cnt++;
        if (!i_reset && o_tx_valid) begin
            if (i_tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_byte", 32'(o_tx_data), 32'(e));
                end
            end else begin
                hold_pending = 1'b1;
                held         = o_tx_data;
            end
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        monitor();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
    endtask

    task automatic start_frame(input logic [31:0] p, input logic [31:0] r, input logic [31:0] t,
                               input logic [31:0] s, input logic [17:0] c);
        logic [23:0] cpad;
        pc = p; rs = r; rt = t; se = s; ctrl = c;
        cpad = {6'b0, c};
        exp_q.push_back(8'hA5);
        push_word(p); push_word(r); push_word(t); push_word(s);
        exp_q.push_back(cpad[23:16]);
        exp_q.push_back(cpad[15:8]);
        exp_q.push_back(cpad[7:0]);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1,0,0,...
    task automatic run_to_done(input int mode);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < 200) begin
            i_tx_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
            tick();
            k++;
        end
        check("done_in_budget", 32'(done_cnt), 32'(d0 + 1));
        check("idle_valid", 32'(o_tx_valid), 32'd0);
        check("idle_busy", 32'(o_busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int d0;
        i_reset = 1'b1; i_start = 1'b0; i_tx_ready = 1'b0;
        pc = '0; rs = '0; rt = '0; se = '0; ctrl = '0;
        repeat (3) tick();
        check("rst_data", 32'(o_tx_data), 32'd0);
        check("rst_valid", 32'(o_tx_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        i_reset = 1'b0;
        tick();

        // Basic dump with exact cycle timing
        i_tx_ready = 1'b1;
        start_frame(32'h00000008, 32'h11223344, 32'hDEADBEEF, 32'hFFFFFF80, 18'h2ABCD);
        for (int k = 0; k < 20; k++) begin
            check("basic_valid", 32'(o_tx_valid), 32'd1);
            check("basic_busy", 32'(o_busy), 32'd1);
            tick();
        end
        check("basic_done_hi", 32'(o_done), 32'd1);
        check("basic_busy_lo", 32'(o_busy), 32'd0);
        check("basic_valid_lo", 32'(o_tx_valid), 32'd0);
        tick();
        check("basic_done_lo", 32'(o_done), 32'd0);
        check("basic_queue", 32'(exp_q.size()), 32'd0);
        check("basic_done_cnt", 32'(done_cnt), 32'd1);

        // Backpressure
        start_frame(32'h00000008, 32'h11223344, 32'hDEADBEEF, 32'hFFFFFF80, 18'h2ABCD);
        run_to_done(1);

        // Snapshot isolation
        i_tx_ready = 1'b1;
        start_frame(32'hCAFEF00D, 32'h01020304, 32'h80000001, 32'h0000007F, 18'h15A5A);
        pc = '0; rs = '0; rt = '0; se = '0; ctrl = '0;
        run_to_done(0);

        // Start while busy: pulses at byte 5, byte 19 and the DONE cycle
        d0 = done_cnt;
        i_tx_ready = 1'b1;
        start_frame(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0, 18'h00001);
        for (int k = 0; k <= 20; k++) begin
            i_start = (k == 5 || k == 19 || k == 20);
            tick();
        end
        i_start = 1'b0;
        check("busy_start_done_cnt", 32'(done_cnt), 32'(d0 + 1));
        check("busy_start_no_queue_valid", 32'(o_tx_valid), 32'd0);
        check("busy_start_no_queue_busy", 32'(o_busy), 32'd0);
        check("busy_start_queue", 32'(exp_q.size()), 32'd0);
        start_frame(32'hA1B2C3D4, 32'h55AA55AA, 32'h00FF00FF, 32'hFFFF0000, 18'h3C3C3);
        check("relaunch_valid", 32'(o_tx_valid), 32'd1);
        check("relaunch_header", 32'(o_tx_data), 32'hA5);
        run_to_done(0);

        // Reset after byte 7 is accepted
        d0 = done_cnt;
        i_tx_ready = 1'b1;
        start_frame(32'h76543210, 32'hFEDCBA98, 32'h13579BDF, 32'h2468ACE0, 18'h12345);
        repeat (8) tick();
        i_reset = 1'b1;
        tick();
        check("midrst_valid", 32'(o_tx_valid), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_done", 32'(o_done), 32'd0);
        exp_q.delete();
        hold_pending = 1'b0;
        i_reset = 1'b0;
        tick();
        check("midrst_no_done", 32'(done_cnt), 32'(d0));
        start_frame(32'h00000008, 32'h11223344, 32'hDEADBEEF, 32'hFFFFFF80, 18'h2ABCD);
        check("postrst_header", 32'(o_tx_data), 32'hA5);
        run_to_done(0);

        // Control padding
        start_frame(32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 18'h3FFFF);
        run_to_done(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
